// File: rtl/rst_seq_pkg.sv
// rst_sequencer shared types: FSM states, reset-cause codes
// and counter sizing helper.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    HOLD,
    REL_PERIPH,
    RUN
  } state_e;

  localparam logic [1:0] CAUSE_PIN  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_cell.sv
// N-stage synchronizer, cleared asynchronously by rst_n.
// Used for both the reset-release chain and the PLL lock.
module sync_cell #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // shift d_i through N flops; rst_n clears the whole chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/rst_sequencer.sv
// Board reset conditioner: ordered periph/core release.
// Optional watchdog: define RST_SEQ_WDT_EN.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 16,
  parameter int PERIPH_DELAY = 8,
  parameter int WDT_CYCLES   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  input  logic       wdt_kick,
  output logic       periph_rst,
  output logic       soc_rst,
  output logic       ready,
  output logic [1:0] rst_cause
);

  localparam int CW =
    cnt_width(HOLD_CYCLES, PERIPH_DELAY, WDT_CYCLES);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] PDLY_LAST =
    CW'(PERIPH_DELAY - 1);

  logic rst_ok;
  logic lock_s;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          periph_q;
  logic          soc_q;
  logic          ready_q;
  logic [1:0]    cause_q;

  sync_cell #(
    .N(SYNC_STAGES)
  ) u_rst_ok (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (1'b1),
    .q_o  (rst_ok)
  );

  sync_cell #(
    .N(SYNC_STAGES)
  ) u_lock (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (pll_locked),
    .q_o  (lock_s)
  );

`ifdef RST_SEQ_WDT_EN
  localparam logic [CW-1:0] WDT_LAST =
    CW'(WDT_CYCLES - 1);

  logic wdt_exp;
  assign wdt_exp = (cnt_q == WDT_LAST) && !wdt_kick;
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
`endif

  // sequencer FSM; every pin is a flop written here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RESET;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      soc_q    <= 1'b1;
      ready_q  <= 1'b0;
      cause_q  <= CAUSE_PIN;
    end else begin
      unique case (state_q)
        RESET: begin
          if (rst_ok) state_q <= WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q  <= REL_PERIPH;
            cnt_q    <= '0;
            periph_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        REL_PERIPH: begin
          if (!lock_s) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b1;
          end else if (cnt_q == PDLY_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            soc_q   <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            soc_q    <= 1'b1;
            ready_q  <= 1'b0;
            cause_q  <= CAUSE_LOCK;
          end
`ifdef RST_SEQ_WDT_EN
          else if (wdt_exp) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            soc_q    <= 1'b1;
            ready_q  <= 1'b0;
            cause_q  <= CAUSE_WDT;
          end
`endif
          else if (sw_rst_req) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            soc_q    <= 1'b1;
            ready_q  <= 1'b0;
            cause_q  <= CAUSE_SW;
          end
`ifdef RST_SEQ_WDT_EN
          else if (wdt_kick) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
`endif
        end
        default: begin
          state_q  <= RESET;
          cnt_q    <= '0;
          periph_q <= 1'b1;
          soc_q    <= 1'b1;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign periph_rst = periph_q;
  assign soc_rst    = soc_q;
  assign ready      = ready_q;
  assign rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: timeline model plus
// directed reset, lock-loss, software and watchdog cases.
module tb_rst_sequencer;

  localparam int S = 2;
  localparam int H = 16;
  localparam int P = 8;
  localparam int W = 100;
`ifdef RST_SEQ_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       wdt_kick;
  logic       periph_rst;
  logic       soc_rst;
  logic       ready;
  logic [1:0] rst_cause;

  int total = 0;
  int bad   = 0;

  rst_sequencer #(
    .SYNC_STAGES (S),
    .HOLD_CYCLES (H),
    .PERIPH_DELAY(P),
    .WDT_CYCLES  (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req),
    .wdt_kick  (wdt_kick),
    .periph_rst(periph_rst),
    .soc_rst   (soc_rst),
    .ready     (ready),
    .rst_cause (rst_cause)
  );

  always #5 clk = ~clk;

  // Model: phase 0 waits for release sync, phase 1 waits
  // for seen lock, phase 2 is a timeline t edges since lock.
  int         m_rel;
  int         m_phase;
  int         m_t;
  int         m_wd;
  logic [1:0] m_cause;
  logic       m_hist [S];

  always @(posedge clk or negedge rst_n) begin
    logic ls;
    bit   run;
    if (!rst_n) begin
      m_rel   = 0;
      m_phase = 0;
      m_t     = 0;
      m_wd    = 0;
      m_cause = 2'b00;
      for (int i = 0; i < S; i++) m_hist[i] = 1'b0;
    end else begin
      ls = m_hist[S-1];
      for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pll_locked;
      case (m_phase)
        0: if (m_rel >= S) m_phase = 1;
        1: if (ls) begin
          m_phase = 2;
          m_t     = 0;
        end
        default: begin
          run = (m_t >= H + P);
          if (!ls) begin
            if (run) m_cause = 2'b01;
            m_phase = 1;
          end else if (WDT_ON && run && m_wd == W - 1 && !wdt_kick) begin
            m_cause = 2'b11;
            m_phase = 1;
          end else if (run && sw_rst_req) begin
            m_cause = 2'b10;
            m_phase = 1;
          end else if (run) begin
            m_wd = wdt_kick ? 0 : m_wd + 1;
          end else begin
            m_t = m_t + 1;
            if (m_t == H + P) m_wd = 0;
          end
        end
      endcase
      if (m_rel < 1000) m_rel = m_rel + 1;
    end
  end

  function automatic logic mdl_periph();
    return !(m_phase == 2 && m_t >= H);
  endfunction

  function automatic logic mdl_soc();
    return !(m_phase == 2 && m_t >= H + P);
  endfunction

  task automatic chk(input string name,
                     input logic [1:0] act,
                     input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t",
               name, act, exp, $time);
    end
  endtask

  // compare DUT to model every cycle on the falling edge
  always @(negedge clk) begin
    chk("m_periph", {1'b0, periph_rst}, {1'b0, mdl_periph()});
    chk("m_soc", {1'b0, soc_rst}, {1'b0, mdl_soc()});
    chk("m_ready", {1'b0, ready}, {1'b0, !mdl_soc()});
    chk("m_cause", rst_cause, m_cause);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // periph_rst must fall on edge 'first', soc_rst P later
  task automatic expect_release(input int first);
    tick(first - 1);
    chk("periph_hold", {1'b0, periph_rst}, 2'b01);
    tick(1);
    chk("periph_rel", {1'b0, periph_rst}, 2'b00);
    chk("soc_hold0", {1'b0, soc_rst}, 2'b01);
    tick(P - 1);
    chk("soc_hold", {1'b0, soc_rst}, 2'b01);
    chk("ready_lo", {1'b0, ready}, 2'b00);
    tick(1);
    chk("soc_rel", {1'b0, soc_rst}, 2'b00);
    chk("ready_hi", {1'b0, ready}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_periph", {1'b0, periph_rst}, 2'b01);
    chk("rst_soc", {1'b0, soc_rst}, 2'b01);
    chk("rst_ready", {1'b0, ready}, 2'b00);
    chk("rst_cause", rst_cause, 2'b00);

    // power-up
    rst_n = 1'b1;
    expect_release(S + 2 + H);
    chk("pwr_cause", rst_cause, 2'b00);

    // short pin pulse mid-RUN
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("pin_periph", {1'b0, periph_rst}, 2'b01);
    chk("pin_soc", {1'b0, soc_rst}, 2'b01);
    #2;
    rst_n = 1'b1;
    expect_release(S + 2 + H);
    chk("pin_cause", rst_cause, 2'b00);

    // lock loss in RUN for 10 cycles
    tick(3);
    pll_locked = 1'b0;
    tick(S);
    chk("lock_soc_pre", {1'b0, soc_rst}, 2'b00);
    tick(1);
    chk("lock_soc", {1'b0, soc_rst}, 2'b01);
    chk("lock_periph", {1'b0, periph_rst}, 2'b01);
    chk("lock_cause", rst_cause, 2'b01);
    tick(10 - S - 1);
    pll_locked = 1'b1;
    expect_release(S + 1 + H);
    chk("relock_cause", rst_cause, 2'b01);

    // software reset in RUN, then ignored pulse in HOLD
    tick(3);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("sw_soc", {1'b0, soc_rst}, 2'b01);
    chk("sw_periph", {1'b0, periph_rst}, 2'b01);
    chk("sw_cause", rst_cause, 2'b10);
    tick(6);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    expect_release(10);
    chk("sw_hold_cause", rst_cause, 2'b10);

    // software request coinciding with lock loss
    tick(3);
    pll_locked = 1'b0;
    tick(S);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("both_soc", {1'b0, soc_rst}, 2'b01);
    chk("both_cause", rst_cause, 2'b01);
    pll_locked = 1'b1;
    expect_release(S + 1 + H);

`ifdef RST_SEQ_WDT_EN
    // regular kicks keep RUN; silence times out
    for (int k = 0; k < 6; k++) begin
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
      tick(49);
      chk("wdt_kept", {1'b0, ready}, 2'b01);
    end
    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    tick(W - 1);
    chk("wdt_pre", {1'b0, ready}, 2'b01);
    tick(1);
    chk("wdt_ready", {1'b0, ready}, 2'b00);
    chk("wdt_soc", {1'b0, soc_rst}, 2'b01);
    chk("wdt_cause", rst_cause, 2'b11);
    tick(40);
`else
    // kicks have no effect without the watchdog
    wdt_kick = 1'b1;
    tick(5);
    wdt_kick = 1'b0;
    chk("nowdt_ready", {1'b0, ready}, 2'b01);
    chk("nowdt_cause", rst_cause, 2'b01);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
